// File: rtl/game_pkg.sv
// Shared game definitions: status codes, cell encoding, checker FSM states
// and a helper that pulls one cell out of a packed 3x3 board.
package game_pkg;

    localparam logic [7:0] ST_PLAYING = 8'h00;
    localparam logic [7:0] ST_P1_WIN  = 8'h01;
    localparam logic [7:0] ST_P2_WIN  = 8'h02;
    localparam logic [7:0] ST_DRAW    = 8'h03;

    localparam int NUM_CELLS  = 9;
    localparam int BOARD_BITS = 2 * NUM_CELLS;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        P1      = 2'b01,
        P2      = 2'b10,
        INVALID = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        LOCKED
    } state_t;

    function automatic cell_t get_cell(input logic [BOARD_BITS-1:0] b, input logic [3:0] idx);
        logic [4:0] lsb;
        lsb = {idx, 1'b0};
        return cell_t'(b[lsb +: 2]);
    endfunction

endpackage

// File: rtl/win_checker_if.sv
// Request/status bundle between the game controller and the win checker.
interface win_checker_if;

    logic        check_req;
    logic        game_clear;
    logic [17:0] board;
    logic        busy;
    logic        write_en;
    logic [7:0]  new_state;
    logic        game_over;

    modport master (
        output check_req, game_clear, board,
        input  busy, write_en, new_state, game_over
    );

    modport slave (
        input  check_req, game_clear, board,
        output busy, write_en, new_state, game_over
    );

endinterface

// File: rtl/win_line_rom.sv
// The eight winning lines of a 3x3 board as cell-index triples.
module win_line_rom (
    input  logic [2:0] line_idx,
    output logic [3:0] cell_a,
    output logic [3:0] cell_b,
    output logic [3:0] cell_c
);

    always_comb begin
        case (line_idx)
            3'd0:    {cell_a, cell_b, cell_c} = {4'd0, 4'd1, 4'd2};
            3'd1:    {cell_a, cell_b, cell_c} = {4'd3, 4'd4, 4'd5};
            3'd2:    {cell_a, cell_b, cell_c} = {4'd6, 4'd7, 4'd8};
            3'd3:    {cell_a, cell_b, cell_c} = {4'd0, 4'd3, 4'd6};
            3'd4:    {cell_a, cell_b, cell_c} = {4'd1, 4'd4, 4'd7};
            3'd5:    {cell_a, cell_b, cell_c} = {4'd2, 4'd5, 4'd8};
            3'd6:    {cell_a, cell_b, cell_c} = {4'd0, 4'd4, 4'd8};
            default: {cell_a, cell_b, cell_c} = {4'd2, 4'd4, 4'd6};
        endcase
    end

endmodule

// File: rtl/win_checker.sv
// Scans a snapshot of the board one line per cycle and reports the game
// status to a downstream register through a single-cycle write strobe.
module win_checker
    import game_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    win_checker_if.slave  bus
);

    state_t                  state_q, state_d;
    logic [2:0]              line_idx_q, line_idx_d;
    logic [BOARD_BITS-1:0]   snap_q, snap_d;
    logic                    write_en_q, write_en_d;
    logic [7:0]              new_state_q, new_state_d;
    logic                    busy_q, busy_d;
    logic                    game_over_q, game_over_d;

    logic [3:0]              idx_a, idx_b, idx_c;
    cell_t                   cell_a, cell_b, cell_c;
    logic [NUM_CELLS-1:0]    cell_empty;
    logic                    p1_line, p2_line;

    win_line_rom u_line_rom (
        .line_idx (line_idx_q),
        .cell_a   (idx_a),
        .cell_b   (idx_b),
        .cell_c   (idx_c)
    );

    assign cell_a = get_cell(snap_q, idx_a);
    assign cell_b = get_cell(snap_q, idx_b);
    assign cell_c = get_cell(snap_q, idx_c);

    // INVALID cells never match P1/P2, so they cannot complete a line.
    assign p1_line = (cell_a == P1) && (cell_b == P1) && (cell_c == P1);
    assign p2_line = (cell_a == P2) && (cell_b == P2) && (cell_c == P2);

    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_empty
            assign cell_empty[gi] = (snap_q[2*gi +: 2] == EMPTY);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        line_idx_d  = line_idx_q;
        snap_d      = snap_q;
        write_en_d  = 1'b0;
        new_state_d = new_state_q;

        if (bus.game_clear) begin
            state_d     = IDLE;
            line_idx_d  = 3'd0;
            write_en_d  = 1'b1;
            new_state_d = ST_PLAYING;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.check_req) begin
                        snap_d     = bus.board;
                        line_idx_d = 3'd0;
                        state_d    = SCAN;
                    end
                end
                SCAN: begin
                    if (p1_line) begin
                        new_state_d = ST_P1_WIN;
                        write_en_d  = 1'b1;
                        state_d     = WRITE;
                    end else if (p2_line) begin
                        new_state_d = ST_P2_WIN;
                        write_en_d  = 1'b1;
                        state_d     = WRITE;
                    end else if (line_idx_q == 3'd7) begin
                        new_state_d = (|cell_empty) ? ST_PLAYING : ST_DRAW;
                        write_en_d  = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        line_idx_d = line_idx_q + 3'd1;
                    end
                end
                // The strobe is already high during WRITE; only the exit is decided here.
                WRITE: begin
                    state_d = (new_state_q != ST_PLAYING) ? LOCKED : IDLE;
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d      = (state_d == SCAN) || (state_d == WRITE);
        game_over_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            line_idx_q  <= 3'd0;
            snap_q      <= '0;
            write_en_q  <= 1'b0;
            new_state_q <= ST_PLAYING;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_idx_q  <= line_idx_d;
            snap_q      <= snap_d;
            write_en_q  <= write_en_d;
            new_state_q <= new_state_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.write_en  = write_en_q;
    assign bus.new_state = new_state_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: a timeline model of the expected status
// strobes is compared against the DUT every cycle, plus literal scenario checks.
module tb_win_checker;

    logic clk;
    logic rst;

    win_checker_if bus ();

    win_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Winning lines written straight from the rules of the game.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    // Result code and the index of the line on which the scan stops.
    function automatic void evaluate(input logic [17:0] b, output int res, output int line);
        int c [9];
        for (int i = 0; i < 9; i++) c[i] = int'((b >> (2*i)) & 18'h3);
        for (int l = 0; l < 8; l++) begin
            if (c[lines[l][0]] == 1 && c[lines[l][1]] == 1 && c[lines[l][2]] == 1) begin
                res = 1; line = l; return;
            end
            if (c[lines[l][0]] == 2 && c[lines[l][1]] == 2 && c[lines[l][2]] == 2) begin
                res = 2; line = l; return;
            end
        end
        line = 7;
        res  = 3;
        for (int i = 0; i < 9; i++) if (c[i] == 0) res = 0;
    endfunction

    // Timeline model: after an accepted request the strobe fires line+1 edges later.
    typedef enum {M_IDLE, M_PEND, M_OUT, M_LOCK} mmode_t;
    mmode_t m_mode = M_IDLE;
    int m_cnt = 0, m_res = 0, m_line = 0;
    int exp_we = 0, exp_ns = 0, exp_busy = 0, exp_go = 0;

    initial begin
        forever begin
            @(posedge clk);
            exp_we = 0;
            if (!rst) begin
                m_mode = M_IDLE;
                exp_ns = 0;
            end else if (bus.game_clear) begin
                m_mode = M_IDLE;
                exp_we = 1;
                exp_ns = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (bus.check_req) begin
                        evaluate(bus.board, m_res, m_line);
                        m_cnt  = m_line + 1;
                        m_mode = M_PEND;
                    end
                    M_PEND: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            exp_we = 1;
                            exp_ns = m_res;
                            m_mode = M_OUT;
                        end
                    end
                    M_OUT:  m_mode = (m_res != 0) ? M_LOCK : M_IDLE;
                    M_LOCK: m_mode = M_LOCK;
                endcase
            end
            exp_busy = (m_mode == M_PEND || m_mode == M_OUT) ? 1 : 0;
            exp_go   = (m_mode == M_LOCK) ? 1 : 0;
            #1;
            chk("cyc_write_en",  int'(bus.write_en),  exp_we);
            chk("cyc_new_state", int'(bus.new_state), exp_ns);
            chk("cyc_busy",      int'(bus.busy),      exp_busy);
            chk("cyc_game_over", int'(bus.game_over), exp_go);
        end
    end

    task automatic issue(input logic [17:0] b);
        @(negedge clk);
        bus.board     = b;
        bus.check_req = 1'b1;
        @(negedge clk);
        bus.check_req = 1'b0;
    endtask

    task automatic wait_we(input int max_cycles, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.write_en) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic count_we(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.write_en) pulses++;
        end
    endtask

    task automatic do_clear(input string name, input logic with_req);
        @(negedge clk);
        bus.game_clear = 1'b1;
        bus.check_req  = with_req;
        @(posedge clk);
        #1;
        chk({name, "_we"},   int'(bus.write_en),  1);
        chk({name, "_ns"},   int'(bus.new_state), 0);
        chk({name, "_busy"}, int'(bus.busy),      0);
        chk({name, "_go"},   int'(bus.game_over), 0);
        @(negedge clk);
        bus.game_clear = 1'b0;
        bus.check_req  = 1'b0;
        $display("txn clear %s with_req=%0d new_state=%0d", name, with_req, bus.new_state);
    endtask

    task automatic run_check(input string name, input logic [17:0] b, input int exp_lat, input int exp_res);
        int lat;
        issue(b);
        wait_we(12, lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"},  int'(bus.new_state), exp_res);
        $display("txn check %s board=%05h latency=%0d new_state=%0d", name, b, lat, bus.new_state);
    endtask

    initial begin
        int r, l, n, lat;
        rst            = 1'b0;
        bus.check_req  = 1'b0;
        bus.game_clear = 1'b0;
        bus.board      = '0;

        @(posedge clk);
        #1;
        chk("reset_we",   int'(bus.write_en),  0);
        chk("reset_ns",   int'(bus.new_state), 0);
        chk("reset_busy", int'(bus.busy),      0);
        chk("reset_go",   int'(bus.game_over), 0);

        evaluate(18'h00015, r, l); chk("pin_row0_res", r, 1); chk("pin_row0_line", l, 0);
        evaluate(18'h02220, r, l); chk("pin_anti_res", r, 2); chk("pin_anti_line", l, 7);
        evaluate(18'h16A59, r, l); chk("pin_draw_res", r, 3);
        evaluate(18'h00000, r, l); chk("pin_empty_res", r, 0);
        evaluate(18'h0003F, r, l); chk("pin_invalid_row_res", r, 0);
        evaluate(18'h3FFFF, r, l); chk("pin_all_invalid_res", r, 3);

        @(negedge clk);
        rst = 1'b1;

        // P1 top row: decided on line 0, one edge after acceptance.
        run_check("p1_row0", 18'h00015, 1, 1);
        @(posedge clk);
        #1;
        chk("p1_row0_we_drop", int'(bus.write_en),  0);
        chk("p1_row0_locked",  int'(bus.game_over), 1);
        chk("p1_row0_idle",    int'(bus.busy),      0);

        // Request while locked is dropped.
        issue(18'h00000);
        count_we(6, n);
        chk("locked_req_ignored", n, 0);
        chk("locked_still_over", int'(bus.game_over), 1);
        do_clear("clr_locked", 1'b0);

        run_check("p2_anti", 18'h02220, 8, 2);
        do_clear("clr_p2", 1'b0);

        run_check("draw", 18'h16A59, 8, 3);
        do_clear("clr_draw", 1'b0);

        run_check("empty", 18'h00000, 8, 0);
        @(posedge clk);
        #1;
        chk("empty_not_over", int'(bus.game_over), 0);
        chk("empty_not_busy", int'(bus.busy),      0);

        // Board changes mid-scan, plus a second request while busy.
        @(negedge clk);
        bus.board     = 18'h00000;
        bus.check_req = 1'b1;
        @(negedge clk);
        bus.board     = 18'h00015;
        bus.check_req = 1'b1;
        @(negedge clk);
        bus.check_req = 1'b0;
        wait_we(12, lat);
        chk("snapshot_latency", lat, 7);
        chk("snapshot_result",  int'(bus.new_state), 0);
        $display("txn check snapshot latency=%0d new_state=%0d", lat, bus.new_state);
        count_we(10, n);
        chk("busy_req_ignored", n, 0);

        // Clear coincident with a request: single 00 pulse, no scan.
        run_check("p1_again", 18'h00015, 1, 1);
        do_clear("clr_with_req", 1'b1);
        count_we(10, n);
        chk("clr_req_no_scan", n, 0);
        chk("clr_req_ns_hold", int'(bus.new_state), 0);

        // Reset in the middle of a scan.
        issue(18'h02220);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_we",   int'(bus.write_en),  0);
        chk("midrst_ns",   int'(bus.new_state), 0);
        chk("midrst_busy", int'(bus.busy),      0);
        chk("midrst_go",   int'(bus.game_over), 0);
        count_we(12, n);
        chk("midrst_no_pulse", n, 0);
        @(negedge clk);
        rst           = 1'b1;
        bus.board     = 18'h00015;
        bus.check_req = 1'b1;
        @(negedge clk);
        bus.check_req = 1'b0;
        wait_we(12, lat);
        chk("post_rst_latency", lat, 1);
        chk("post_rst_result",  int'(bus.new_state), 1);
        $display("txn check post_reset latency=%0d new_state=%0d", lat, bus.new_state);

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 The block SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 The block SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have port: check_req  input  1  one-cycle pulse requesting evaluation of board.
REQ-004 The block SHALL have port: game_clear  input  1  one-cycle pulse starting a new game.
REQ-005 The block SHALL have port: board  input  18  3x3 board, cell i = row*3+col at bits [2i+1:2i]; 00 empty, 01 P1, 10 P2, 11 invalid.
REQ-006 The block SHALL have port: busy  output  1  high while in SCAN or WRITE.
REQ-007 The block SHALL have port: write_en  output  1  one-cycle strobe to the downstream status register.
REQ-008 The block SHALL have port: new_state  output  8  result code, valid while write_en is high.
REQ-009 The block SHALL have port: game_over  output  1  high while in LOCKED.

Function
REQ-010 The FSM SHALL have the states IDLE, SCAN, WRITE and LOCKED.
REQ-011 In IDLE, a check_req SHALL snapshot board into an internal register, clear line index to 0, and enter SCAN.
REQ-012 SCAN SHALL evaluate one line per cycle, on the snapshot only, in order: rows 0-2, columns 0-2, diagonal (0,4,8), anti-diagonal (2,4,6); line index 0..7.
REQ-013 A line whose three cells are all 01 SHALL set result 8'h01 and move to WRITE immediately, skipping the remaining lines.
REQ-014 A line whose three cells are all 10 SHALL set result 8'h02 and move to WRITE immediately.
REQ-015 Cells equal to 11 SHALL never form a win and SHALL count as occupied.
REQ-016 After line 7 without a win, the result SHALL be 8'h03 (draw) if no cell is 00, else 8'h00 (playing), followed by a move to WRITE.
REQ-017 WRITE SHALL assert write_en for exactly one cycle with new_state = result, then enter LOCKED if result != 00, else IDLE.
REQ-018 Latency SHALL be: check_req sampled at edge k, line j decided at edge k+1+j, write_en high from that edge until the next; worst case is write_en high after edge k+8.
REQ-019 check_req in SCAN, WRITE or LOCKED SHALL be ignored, with no queuing.
REQ-020 Board changes after the snapshot SHALL NOT affect the in-flight result.
REQ-021 game_clear in any state SHALL abort any scan, go to IDLE, and produce exactly one write_en pulse with new_state 8'h00 in the following cycle.
REQ-022 If game_clear and check_req are high in the same cycle, game_clear SHALL take priority and check_req SHALL be dropped.
REQ-023 write_en SHALL be a registered output, and new_state SHALL hold its last written value when write_en is low.

Reset
REQ-024 While rst is low, the block SHALL force state to IDLE, line index to 0, snapshot to 0, write_en to 0, new_state to 8'h00, busy to 0 and game_over to 0, asynchronously.
REQ-025 Reset asserted mid-scan SHALL discard the scan and SHALL NOT emit a write_en pulse.
REQ-026 The first check_req SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-027 Shared package game_pkg SHALL hold: result codes ST_PLAYING=8'h00, ST_P1_WIN=8'h01, ST_P2_WIN=8'h02, ST_DRAW=8'h03; the cell enum (EMPTY, P1, P2, INVALID); and the FSM state typedef.
REQ-028 A combinational sub-module win_line_rom SHALL map the 3-bit line index to three 4-bit cell indices.
REQ-029 The line table in win_line_rom SHALL be the only copy in the design.

Verification
REQ-030 Scenario: board P1 on cells 0,1,2, check_req -> write_en exactly one cycle after the accepting edge, new_state 01, game_over 1, busy 0.
REQ-031 Scenario: board P2 on cells 2,4,6 (line 7), check_req -> write_en after 8 scan cycles, new_state 02.
REQ-032 Scenario: full board with no line (P1 on 0,2,3,7,8; P2 on 1,4,5,6) -> new_state 03; an empty board -> new_state 00 and return to IDLE.
REQ-033 Scenario: change board to a P1 row win during SCAN -> result still from the snapshot (00); a check_req during busy or LOCKED produces no extra write_en.
REQ-034 Scenario: game_clear while LOCKED, and game_clear coincident with check_req -> single write_en with 00, state IDLE, no scan started.
REQ-035 Scenario: rst low at scan cycle 3 -> no write_en, all outputs 0; after release, check_req works normally.
